bcd_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter.sv | 34 +++
 tb/tb_bcd_counter.sv | 118 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter: digit width, digit constants, the digit
// type and the per-digit increment function.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Next value of an enabled digit. Codes 10..15 cannot arise after a clear, but if
  // one does appear it is treated like 9 and wraps to zero.
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    bcd_digit_t r;
    if (d >= BCD_MAX) begin
      r = BCD_ZERO;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the cascaded counter.
//   clock     : system clock, state updates on the rising edge
//   clear     : synchronous active-high clear, wins over counting
//   en        : advance this digit on the next edge
//   digit     : registered digit value
//   carry_out : this digit wraps on the next edge; enables the next digit
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (en) begin
      digit_d = bcd_inc(digit_q);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

  // Only a true 9 carries; an illegal code wraps locally without disturbing the
  // higher digits.
  assign carry_out = en && (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_counter.sv
// Synchronous cascaded BCD up-counter. Advances by one every rising edge and wraps
// from all-nines to zero.
//   DIGITS : number of cascaded BCD digits (1..8)
//   clock  : system clock
//   clear  : synchronous active-high clear, forces every digit to zero
//   count  : registered count, digit k in bits [4k+3:4k]
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 1
) (
  input  logic                      clock,
  input  logic                      clear,
  output logic [BCD_W*DIGITS-1:0]   count
);

  // carry[k] enables digit k; it is the AND of "digit j == 9" over all j < k.
  logic [DIGITS:0] carry;
  logic            unused_carry;

  assign carry[0]     = 1'b1;
  assign unused_carry = carry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .clear     (clear),
      .en        (carry[g]),
      .digit     (count[BCD_W*g +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: one single-digit instance and one two-digit
// instance on a shared 20 ns clock, outputs sampled on the falling edge.
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       clear1 = 1'b1;
  logic       clear2 = 1'b1;
  logic [3:0] count1;
  logic [7:0] count2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #10 clk = ~clk;

  bcd_counter #(.DIGITS(1)) u_dut1 (
    .clock (clk),
    .clear (clear1),
    .count (count1)
  );

  bcd_counter #(.DIGITS(2)) u_dut2 (
    .clock (clk),
    .clear (clear2),
    .count (count2)
  );

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  initial begin
    int unsigned exp1;

    // Single digit: reset on edge 10, release before edge 30.
    @(negedge clk);
    check_val("reset1", {4'h0, count1}, 8'h00);
    check_val("reset2", count2, 8'h00);
    clear1 = 1'b0;
    exp1 = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp1 = i % 10;
      check_val($sformatf("run1_%0d", i), {4'h0, count1}, 8'(exp1));
    end
    // Advance 4 -> 5, then a single-edge clear.
    @(negedge clk);
    check_val("to5", {4'h0, count1}, 8'h05);
    clear1 = 1'b1;
    @(negedge clk);
    check_val("clr_pulse", {4'h0, count1}, 8'h00);
    clear1 = 1'b0;
    @(negedge clk);
    check_val("after_pulse", {4'h0, count1}, 8'h01);
    // Clear held across several edges.
    clear1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("clr_hold_%0d", i), {4'h0, count1}, 8'h00);
    end
    clear1 = 1'b0;
    @(negedge clk);
    check_val("after_hold", {4'h0, count1}, 8'h01);
    @(negedge clk);
    check_val("after_hold2", {4'h0, count1}, 8'h02);
    // Clear glitch between edges is never sampled.
    #3 clear1 = 1'b1;
    #3 clear1 = 1'b0;
    @(negedge clk);
    check_val("glitch", {4'h0, count1}, 8'h03);
    @(negedge clk);
    check_val("glitch2", {4'h0, count1}, 8'h04);

    // Two digits: 100 edges covering 09->10, 19->20 and 99->00.
    check_val("held2", count2, 8'h00);
    clear2 = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      check_val($sformatf("run2_%0d", n), count2, to_bcd2(n % 100));
    end
    // Advance to 93.
    repeat (93) @(negedge clk);
    check_val("at93", count2, 8'h93);

    // Illegal ones digit with tens at 9: wraps locally, no carry into tens.
    force u_dut2.g_digit[0].u_digit.digit_q = 4'hC;
    #1 release u_dut2.g_digit[0].u_digit.digit_q;
    @(negedge clk);
    check_val("ones_illegal", count2, 8'h90);
    @(negedge clk);
    check_val("ones_recover", count2, 8'h91);

    // Illegal tens digit holds until enabled, then wraps to 0.
    force u_dut2.g_digit[1].u_digit.digit_q = 4'hC;
    #1 release u_dut2.g_digit[1].u_digit.digit_q;
    @(negedge clk);
    check_val("tens_hold", count2, 8'hC2);
    repeat (7) @(negedge clk);
    check_val("tens_hold9", count2, 8'hC9);
    @(negedge clk);
    check_val("tens_wrap", count2, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
